// File: rtl/ss_scan_driver_if.sv
// ss_scan_driver_if: display-side bundle of the 7-segment scan driver.
//   master (controller / testbench): drives enable, load, digits_in; observes the outputs.
//   slave  (ss_scan_driver):         consumes enable, load, digits_in; drives data,
//                                    digit_sel, blank, frame_done.
// Signals:
//   enable     1            1 = scanning runs, 0 = display dark with scan position held
//   load       1            single-cycle strobe, captures digits_in into the shadow register
//   digits_in  4*NUM_DIGITS packed BCD, nibble k = digit k, digit 0 = rightmost
//   data       4            BCD code of the active digit, to the segment decoder
//   digit_sel  NUM_DIGITS   active-low one-cold digit enable, all ones = dark
//   blank      1            1 = segment outputs must be forced off
//   frame_done 1            one-cycle pulse when the last digit slot ends
interface ss_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [3:0]              data;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    blank;
  logic                    frame_done;

  modport master (
    output enable, load, digits_in,
    input  data, digit_sel, blank, frame_done
  );

  modport slave (
    input  enable, load, digits_in,
    output data, digit_sel, blank, frame_done
  );
endinterface

// File: rtl/ss_scan_driver.sv
// ss_scan_driver: time-multiplexed scan controller for a multi-digit 7-segment display.
// Captures a packed BCD vector into a shadow register and walks the digits one slot at a
// time. Each slot lasts SCAN_DIV cycles: BLANK_CYCLES dark cycles (anti-ghosting gap)
// followed by the lit part, where the digit's active-low enable is driven low and its
// code is presented on data. Codes A..F are passed through but always force blank.
// All outputs are registered.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ss_scan_driver_if.slave (enable, load, digits_in -> data, digit_sel, blank,
//          frame_done)
//
// Optional build macro SS_LEADING_ZERO_BLANK_EN: when defined, a digit k>0 whose value and
// all higher digits are zero is kept dark (digit_sel bit high, blank=1) during its slot.
// Digit 0 is never suppressed; slot timing and frame_done are unaffected.
module ss_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input logic            clk,
  input logic            rst_n,
  ss_scan_driver_if.slave bus
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] SlotLast  = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StShow
  } state_e;

  logic [4*NUM_DIGITS-1:0] shadow_q;
  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [3:0]              data_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic                    blank_q;
  logic                    frame_q;

  logic [IdxW-1:0]         idx_inc;
  logic [3:0]              cur_nib;
  logic [3:0]              inc_nib;
  logic [NUM_DIGITS-1:0]   show_sel;
  logic                    show_blank;

  // Shadow register: loads accepted in any state; a mid-slot load just changes what the
  // current slot displays from the next cycle on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (bus.load) begin
      shadow_q <= bus.digits_in;
    end
  end

`ifdef SS_LEADING_ZERO_BLANK_EN
  // lz_zero[k]: digit k and every higher digit are zero.
  logic [NUM_DIGITS-1:0] lz_zero;

  always_comb begin
    lz_zero = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lz_zero[k] = ((shadow_q >> (4 * k)) == '0);
    end
  end
`endif

  // Lit-phase outputs for the current index, derived from the current shadow contents.
  always_comb begin
    idx_inc    = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    cur_nib    = shadow_q[4*idx_q +: 4];
    inc_nib    = shadow_q[4*idx_inc +: 4];
    show_sel   = '1;
    show_sel[idx_q] = 1'b0;
    show_blank = (cur_nib > 4'd9);
`ifdef SS_LEADING_ZERO_BLANK_EN
    if ((idx_q != '0) && lz_zero[idx_q]) begin
      show_sel   = '1;
      show_blank = 1'b1;
    end
`endif
  end

  // Scan FSM. Outputs default to dark each cycle and are overridden only on cycles whose
  // next state is a lit SHOW cycle, so outputs always line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= 4'd0;
      sel_q   <= '1;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      data_q  <= cur_nib;
      sel_q   <= '1;
      blank_q <= 1'b1;
      if (!bus.enable) begin
        // Scan position held; counter cleared so re-enable restarts the slot at its gap.
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StGap;
            cnt_q   <= '0;
          end
          StGap: begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == BlankLast) begin
              state_q <= StShow;
              sel_q   <= show_sel;
              blank_q <= show_blank;
            end
          end
          StShow: begin
            if (cnt_q == SlotLast) begin
              cnt_q   <= '0;
              idx_q   <= idx_inc;
              state_q <= StGap;
              data_q  <= inc_nib;
              frame_q <= (idx_q == IdxLast);
            end else begin
              cnt_q   <= cnt_q + CntW'(1);
              sel_q   <= show_sel;
              blank_q <= show_blank;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.digit_sel  = sel_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_ss_scan_driver.sv
// Self-checking bench for ss_scan_driver with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// Each slot is 2 dark cycles followed by 6 lit cycles.
module tb_ss_scan_driver;

  localparam int unsigned ND = 4;

`ifdef SS_LEADING_ZERO_BLANK_EN
  localparam bit Lz = 1'b1;
`else
  localparam bit Lz = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ss_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  ss_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // One digit slot: expected code, lit-phase select/blank, frame_done on the first gap
  // cycle, and an optional load applied on the edge that produces the final lit cycle.
  typedef struct {
    logic [3:0]  data;
    logic [3:0]  sel;
    logic        blank;
    logic        fd;
    logic        ld;
    logic [15:0] ld_val;
  } slot_t;

  slot_t rows[24];

  function automatic slot_t mk(logic [3:0] data, logic [3:0] sel, logic blank, logic fd,
                               logic ld, logic [15:0] ld_val);
    slot_t s;
    s.data   = data;
    s.sel    = sel;
    s.blank  = blank;
    s.fd     = fd;
    s.ld     = ld;
    s.ld_val = ld_val;
    return s;
  endfunction

  task automatic expect_cycle(input string name, input logic [3:0] sel, input logic [3:0] data,
                              input logic blank, input logic fd);
    @(posedge clk);
    #1;
    checks++;
    if (bus.digit_sel !== sel || bus.data !== data || bus.blank !== blank ||
        bus.frame_done !== fd) begin
      failures++;
      $display("FAIL %s @%0t: got sel=%b data=%h blank=%b fd=%b, want sel=%b data=%h blank=%b fd=%b",
               name, $time, bus.digit_sel, bus.data, bus.blank, bus.frame_done,
               sel, data, blank, fd);
    end
  endtask

  task automatic run_slot(input int r);
    string nm;
    nm = $sformatf("slot%0d", r);
    for (int c = 0; c < 8; c++) begin
      if (c == 7 && rows[r].ld) begin
        bus.load      = 1'b1;
        bus.digits_in = rows[r].ld_val;
      end
      if (c < 2) begin
        expect_cycle(nm, 4'b1111, rows[r].data, 1'b1, (c == 0) ? rows[r].fd : 1'b0);
      end else begin
        expect_cycle(nm, rows[r].sel, rows[r].data, rows[r].blank, 1'b0);
      end
      bus.load = 1'b0;
    end
  endtask

  initial begin
    // 16'h4321, two frames
    rows[0]  = mk(4'd1, 4'b1110, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[1]  = mk(4'd2, 4'b1101, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[2]  = mk(4'd3, 4'b1011, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[3]  = mk(4'd4, 4'b0111, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[4]  = mk(4'd1, 4'b1110, 1'b0, 1'b1, 1'b0, 16'h0);
    rows[5]  = mk(4'd2, 4'b1101, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[6]  = mk(4'd3, 4'b1011, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[7]  = mk(4'd4, 4'b0111, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[8]  = mk(4'd1, 4'b1110, 1'b0, 1'b1, 1'b0, 16'h0);
    // after mid-slot load of 16'h4391
    rows[9]  = mk(4'd3, 4'b1011, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[10] = mk(4'd4, 4'b0111, 1'b0, 1'b0, 1'b1, 16'h00A0);
    // 16'h00A0: invalid code in digit 1
    rows[11] = mk(4'd0, 4'b1110, 1'b0, 1'b1, 1'b0, 16'h0);
    rows[12] = mk(4'hA, 4'b1101, 1'b1, 1'b0, 1'b0, 16'h0);
    rows[13] = mk(4'd0, Lz ? 4'b1111 : 4'b1011, Lz, 1'b0, 1'b0, 16'h0);
    rows[14] = mk(4'd0, Lz ? 4'b1111 : 4'b0111, Lz, 1'b0, 1'b1, 16'h0050);
    // 16'h0050: leading zeros
    rows[15] = mk(4'd0, 4'b1110, 1'b0, 1'b1, 1'b0, 16'h0);
    rows[16] = mk(4'd5, 4'b1101, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[17] = mk(4'd0, Lz ? 4'b1111 : 4'b1011, Lz, 1'b0, 1'b0, 16'h0);
    rows[18] = mk(4'd0, Lz ? 4'b1111 : 4'b0111, Lz, 1'b0, 1'b1, 16'h4321);
    // 16'h4321 again, enable drop inside digit 2
    rows[19] = mk(4'd1, 4'b1110, 1'b0, 1'b1, 1'b0, 16'h0);
    rows[20] = mk(4'd2, 4'b1101, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[21] = mk(4'd3, 4'b1011, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[22] = mk(4'd4, 4'b0111, 1'b0, 1'b0, 1'b0, 16'h0);
    rows[23] = mk(4'd1, 4'b1110, 1'b0, 1'b1, 1'b0, 16'h0);

    bus.enable    = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    rst_n         = 1'b0;

    // Reset held while inputs toggle: outputs stay dark, nothing captured.
    for (int i = 0; i < 4; i++) begin
      bus.enable    = i[0];
      bus.load      = 1'b1;
      bus.digits_in = 16'h9876 + 16'(i);
      expect_cycle("reset", 4'b1111, 4'd0, 1'b1, 1'b0);
    end
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    #3 rst_n   = 1'b1;

    repeat (3) expect_cycle("idle_hold", 4'b1111, 4'd0, 1'b1, 1'b0);

    // Load while idle: data reflects the new shadow one cycle after the load edge.
    bus.load      = 1'b1;
    bus.digits_in = 16'h4321;
    expect_cycle("load_lag", 4'b1111, 4'd0, 1'b1, 1'b0);
    bus.load = 1'b0;
    expect_cycle("load_vis", 4'b1111, 4'd1, 1'b1, 1'b0);

    bus.enable = 1'b1;
    for (int r = 0; r <= 8; r++) run_slot(r);

    // Mid-slot load during digit 1.
    repeat (2) expect_cycle("mid_gap", 4'b1111, 4'd2, 1'b1, 1'b0);
    repeat (2) expect_cycle("mid_show", 4'b1101, 4'd2, 1'b0, 1'b0);
    bus.load      = 1'b1;
    bus.digits_in = 16'h4391;
    expect_cycle("mid_old", 4'b1101, 4'd2, 1'b0, 1'b0);
    bus.load = 1'b0;
    repeat (3) expect_cycle("mid_new", 4'b1101, 4'd9, 1'b0, 1'b0);

    for (int r = 9; r <= 20; r++) run_slot(r);

    // Enable drop during digit 2, then resume at the held digit.
    repeat (2) expect_cycle("drop_gap", 4'b1111, 4'd3, 1'b1, 1'b0);
    repeat (2) expect_cycle("drop_show", 4'b1011, 4'd3, 1'b0, 1'b0);
    bus.enable = 1'b0;
    repeat (3) expect_cycle("drop_dark", 4'b1111, 4'd3, 1'b1, 1'b0);
    bus.enable = 1'b1;

    for (int r = 21; r <= 23; r++) run_slot(r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ss_scan_driver.md
Name: ss_scan_driver

Overview:
Time-multiplexed scan controller for a common-anode/common-cathode multi-digit 7-segment display. It captures a packed vector of BCD digits and cycles through them one digit slot at a time. For each slot it presents a 4-bit digit code to the downstream BCD-to-segment decoder and drives the matching active-low digit enable. A short blanking gap is inserted between slots to suppress ghosting.

Parameters:
NUM_DIGITS, 4, number of display digits (2..8)
SCAN_DIV, 50000, clock cycles per digit slot, including the blanking gap (must be > BLANK_CYCLES)
BLANK_CYCLES, 500, cycles at the start of each slot with all digits off (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning runs; 0 = display dark, scan position held
load  in  1  single-cycle strobe; captures digits_in into shadow register
digits_in  in  4*NUM_DIGITS  packed BCD; nibble k = digit k, digit 0 = rightmost
data  out  4  BCD code for the active digit, to the segment decoder
digit_sel  out  NUM_DIGITS  active-low one-cold digit enable; all-ones = dark
blank  out  1  1 = segment outputs must be forced off this cycle
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (async, rst_n=0): shadow=0, idx=0, slot counter=0, state=IDLE, data=4'd0, digit_sel=all ones, blank=1, frame_done=0. All outputs are registered.
- Shadow register: on a rising clk edge with load=1, shadow<=digits_in. The new value is first visible in data one cycle later. Loads are accepted in any state. A load mid-slot updates the current digit without restarting the slot.
- FSM states: IDLE, GAP, SHOW.
  - IDLE: digit_sel=all ones, blank=1. Go to GAP with counter=0 on the cycle after enable=1 is seen.
  - GAP: digit_sel=all ones, blank=1, data=shadow[idx]. Counter increments; at counter==BLANK_CYCLES-1, go to SHOW.
  - SHOW: digit_sel[idx]=0, all other bits 1. data=shadow[idx]. blank=1 only if the nibble >9, else 0. At counter==SCAN_DIV-1: counter<=0, idx<=idx+1 (wrap NUM_DIGITS-1 -> 0), go to GAP.
  - frame_done pulses for exactly one cycle coincident with the SHOW->GAP transition when idx==NUM_DIGITS-1.
- enable=0 in any state: next cycle go to IDLE with outputs dark. idx is held and counter cleared. Re-enable resumes at the held idx, starting from GAP.
- Counter is $clog2(SCAN_DIV) bits and never exceeds SCAN_DIV-1.
- Invalid nibble (A..F) is passed through on data but always paired with blank=1.
- Steady-state period per digit = SCAN_DIV cycles. Frame period = NUM_DIGITS*SCAN_DIV cycles.

Optional Feature:
Macro SS_LEADING_ZERO_BLANK_EN.
- Defined: a digit k>0 is treated as blank (digit_sel[k] held 1, blank=1 during its SHOW) when it and every higher-index digit are 0. Digit 0 is never suppressed. Slot timing and frame_done are unchanged.
- Undefined: all digits are shown, including leading zeros. No extra logic is present.

Test Plan:
(All with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.)
- Reset: hold rst_n=0 while toggling load/enable -> digit_sel=4'b1111, blank=1, data=0, frame_done=0. Release with enable=0 -> stays IDLE.
- Scan order: load 16'h4321, enable=1 -> sequence is 2 dark cycles, then 6 cycles of digit_sel=1110/data=1, repeating for 1101/2, 1011/3, 0111/4. frame_done is high for 1 cycle every 32 cycles.
- Mid-slot load: during the SHOW of digit 1, load 16'h4391 -> data changes to 9 one cycle later, slot length is unaffected.
- Invalid code: load 16'h00A0 -> digit 1 slot shows data=4'hA, blank=1, digit_sel=1101. Other slots have blank=0.
- Enable drop: deassert enable during digit 2 SHOW -> next cycle all dark. Re-enable -> GAP, then digit 2 shown for the full 6 cycles.
- SS_LEADING_ZERO_BLANK_EN defined, load 16'h0050 -> digits 3 and 2 stay dark, digit 1 shows 5, digit 0 shows 0. With the macro undefined, all four digits light.
